// File: rtl/note_sequencer_if.sv
// Song ROM read port shared by the sequencer (master) and the ROM (slave).
// Latency: rom_data is valid exactly one cycle after rom_en.
// Backpressure: none; the ROM always answers a strobe on the next cycle.
//
// Ports:
//   rom_en   - read strobe, one cycle per fetch
//   rom_addr - word address
//   rom_data - {rest, note_idx[5:0], duration[3:0]}
interface note_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [10:0]       rom_data;

    modport master (
        output rom_en,
        output rom_addr,
        input  rom_data
    );

    modport slave (
        input  rom_en,
        input  rom_addr,
        output rom_data
    );
endinterface

// File: rtl/note_sequencer.sv
// Song player: fetches note words from a synchronous ROM and times each note and gap in ticks.
// Latency: play in IDLE to note_on is 3 cycles (FETCH, WAIT, NOTE); a note lasts dur*TICK_DIV cycles.
// Backpressure: none; play/pause/stop are single-cycle pulses, priority stop > pause > play.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   play_i / pause_i  - start or resume / pause while a note or gap is timing
//   stop_i            - abort to IDLE at address 0, no done pulse
//   loop_en_i         - restart from address 0 on the end marker instead of finishing
//   rom               - ROM read port (master side)
//   note_idx_o        - note index for the decoder, held for the whole note
//   note_on_o         - high while a non-rest note sounds
//   busy_o / done_o   - not idle / one-cycle pulse when the song ends without looping
module note_sequencer #(
    parameter int TICK_DIV  = 25_000_000,
    parameter int ADDR_W    = 8,
    parameter int GAP_TICKS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     play_i,
    input  logic                     pause_i,
    input  logic                     stop_i,
    input  logic                     loop_en_i,
    note_sequencer_if.master         rom,
    output logic [5:0]               note_idx_o,
    output logic                     note_on_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_NOTE,
        S_GAP,
        S_PAUSED
    } state_t;

    state_t            state_q, state_d;
    logic              ret_gap_q, ret_gap_d;   // state to resume into: 1 = GAP, 0 = NOTE
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [3:0]        dur_q, dur_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [5:0]        note_q, note_d;
    logic              rest_q, rest_d;
    logic              done_q, done_d;

    logic              timing;
    logic              tick;

    // Tick divider only runs while a note or gap is being timed; PAUSED freezes it.
    assign timing = (state_q == S_NOTE) || (state_q == S_GAP);
    assign tick   = timing && (tick_q == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ret_gap_q <= 1'b0;
            addr_q    <= '0;
            tick_q    <= '0;
            dur_q     <= '0;
            gap_q     <= '0;
            note_q    <= '0;
            rest_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_gap_q <= ret_gap_d;
            addr_q    <= addr_d;
            tick_q    <= tick_d;
            dur_q     <= dur_d;
            gap_q     <= gap_d;
            note_q    <= note_d;
            rest_q    <= rest_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ret_gap_d = ret_gap_q;
        addr_d    = addr_q;
        tick_d    = tick_q;
        dur_d     = dur_q;
        gap_d     = gap_q;
        note_d    = note_q;
        rest_d    = rest_q;
        done_d    = 1'b0;

        // Wrapping on the tick also gives the clear-on-entry for NOTE->GAP.
        if (timing) begin
            tick_d = tick ? '0 : tick_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (play_i) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rom.rom_data[3:0] == 4'd0) begin
                    addr_d = '0;
                    if (loop_en_i) begin
                        state_d = S_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    note_d  = rom.rom_data[9:4];
                    rest_d  = rom.rom_data[10];
                    dur_d   = rom.rom_data[3:0];
                    tick_d  = '0;
                    state_d = S_NOTE;
                end
            end
            S_NOTE: begin
                if (tick) begin
                    dur_d = dur_q - 4'd1;
                    if (dur_q == 4'd1) begin
                        if (GAP_TICKS == 0) begin
                            addr_d  = addr_q + 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            gap_d   = '0;
                            state_d = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            S_PAUSED: begin
                if (play_i) begin
                    state_d = ret_gap_q ? S_GAP : S_NOTE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The pause cycle itself still counts toward the note; the sequencer then
        // parks in PAUSED remembering where it was headed. A pause landing on the
        // cycle that finishes the gap is dropped because FETCH cannot be paused.
        if (timing && pause_i && (state_d == S_NOTE || state_d == S_GAP)) begin
            ret_gap_d = (state_d == S_GAP);
            state_d   = S_PAUSED;
        end

        if (stop_i) begin
            state_d = S_IDLE;
            addr_d  = '0;
            tick_d  = '0;
            dur_d   = '0;
            gap_d   = '0;
            done_d  = 1'b0;
        end
    end

    assign rom.rom_en   = (state_q == S_FETCH);
    assign rom.rom_addr = addr_q;
    assign note_idx_o   = note_q;
    assign note_on_o    = (state_q == S_NOTE) && !rest_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;

endmodule
